// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART bus arbiter.
//   arb_state_e : arbitration FSM state encoding (IDLE / OWN / GAP)
//   TX_IDLE     : inactive level of the active-low transmit start strobe
//   REQ_FETCH   : requester index of the instruction-fetch port
//   REQ_LSU     : requester index of the load/store port
//   rr_pick     : round-robin winner among the two requesters
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU   = 1'b1;

  // Under contention the requester that did not own the channel last wins;
  // otherwise whichever one is asking.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    return (req0 && req1) ? ~last : req1;
  endfunction

endpackage

// File: rtl/uart_bus_arbiter_if.sv
// Requester-side channel of the UART bus arbiter (one instance per requester).
//   req      : requester wants the channel (level, held for whole transaction)
//   done     : transaction-complete pulse
//   tx_start : transmit start, active-low
//   tx_data  : transmit byte
//   grant    : channel owned by this requester
//   tx_done  : UART tx_done gated to this requester
//   rx_do    : UART rx_do gated to this requester
//   rx_data  : UART received byte (broadcast, qualified by rx_do)
// Modports: master = requester side, slave = arbiter side.
interface uart_bus_arbiter_if;

  logic       req;
  logic       done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       grant;
  logic       tx_done;
  logic       rx_do;
  logic [7:0] rx_data;

  modport master (
    output req, done, tx_start, tx_data,
    input  grant, tx_done, rx_do, rx_data
  );

  modport slave (
    input  req, done, tx_start, tx_data,
    output grant, tx_done, rx_do, rx_data
  );

endinterface

// File: rtl/arb_watchdog.sv
// Idle-cycle watchdog for the UART bus arbiter.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   clear  : UART activity this cycle, restarts the idle count
//   enable : a grant is active; count is held at zero otherwise
//   expire : TIMEOUT consecutive idle enabled cycles have elapsed (this cycle)
// TIMEOUT must be nonzero and below 2**TO_W.
module arb_watchdog #(
  parameter int unsigned TO_W    = 16,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LastCount = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count_q;

  // Held at zero outside a grant, so every grant starts from a clean count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (!enable || clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + TO_W'(1);
    end
  end

  assign expire = enable & ~clear & (count_q == LastCount);

endmodule

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing one UART byte channel between two requesters
// (0 = instruction fetch, 1 = load/store unit), with an idle watchdog.
//   clk           : system clock
//   reset         : asynchronous active-low reset
//   req0_bus      : requester 0 channel (slave side)
//   req1_bus      : requester 1 channel (slave side)
//   uart_tx_start : to UART, active-low, owner's tx_start
//   uart_tx_data  : to UART, owner's tx_data
//   uart_tx_done  : UART byte transmitted
//   uart_rx_do    : UART byte received
//   uart_rx_data  : UART received byte
//   busy          : arbiter not idle
//   timeout       : one-cycle pulse when the watchdog reclaims the channel
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned TO_W    = 16,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_bus_arbiter_if.slave    req0_bus,
  uart_bus_arbiter_if.slave    req1_bus,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_done,
  input  logic                 uart_rx_do,
  input  logic [7:0]           uart_rx_data,
  output logic                 busy,
  output logic                 timeout
);

  arb_state_e state_q;
  logic       own_q;
  logic       last_q;
  logic       grant0_q;
  logic       grant1_q;
  logic       timeout_q;

  logic       own_req;
  logic       own_done;
  logic       activity;
  logic       wd_enable;
  logic       expire;

  always_comb begin
    own_req  = (own_q == REQ_LSU) ? req1_bus.req  : req0_bus.req;
    own_done = (own_q == REQ_LSU) ? req1_bus.done : req0_bus.done;
  end

  assign activity  = uart_tx_done | uart_rx_do;
  assign wd_enable = (state_q == ST_OWN);

  arb_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (activity),
    .enable (wd_enable),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      own_q     <= REQ_FETCH;
      last_q    <= REQ_LSU;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req0_bus.req || req1_bus.req) begin
            own_q    <= rr_pick(req0_bus.req, req1_bus.req, last_q);
            grant0_q <= (rr_pick(req0_bus.req, req1_bus.req, last_q) == REQ_FETCH);
            grant1_q <= (rr_pick(req0_bus.req, req1_bus.req, last_q) == REQ_LSU);
            state_q  <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (own_done || !own_req || expire) begin
            state_q   <= ST_GAP;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            last_q    <= own_q;
            // Only a release caused by the watchdog alone is a timeout.
            timeout_q <= !own_done && own_req && expire;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          grant0_q <= 1'b0;
          grant1_q <= 1'b0;
        end
      endcase
    end
  end

  // Routing follows the registered grants, so UART events outside OWN are dropped.
  always_comb begin
    uart_tx_start = TX_IDLE;
    uart_tx_data  = 8'h00;
    if (grant0_q) begin
      uart_tx_start = req0_bus.tx_start;
      uart_tx_data  = req0_bus.tx_data;
    end else if (grant1_q) begin
      uart_tx_start = req1_bus.tx_start;
      uart_tx_data  = req1_bus.tx_data;
    end
  end

  assign req0_bus.grant   = grant0_q;
  assign req1_bus.grant   = grant1_q;
  assign req0_bus.tx_done = uart_tx_done & grant0_q;
  assign req1_bus.tx_done = uart_tx_done & grant1_q;
  assign req0_bus.rx_do   = uart_rx_do & grant0_q;
  assign req1_bus.rx_do   = uart_rx_do & grant1_q;
  assign req0_bus.rx_data = uart_rx_data;
  assign req1_bus.rx_data = uart_rx_data;

  assign busy    = (state_q != ST_IDLE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter with a short watchdog (TIMEOUT = 8).
module tb_uart_bus_arbiter;

  logic       clk;
  logic       reset;
  logic       uart_tx_start;
  logic [7:0] uart_tx_data;
  logic       uart_tx_done;
  logic       uart_rx_do;
  logic [7:0] uart_rx_data;
  logic       busy;
  logic       timeout;

  int n_tests;
  int n_fail;

  uart_bus_arbiter_if r0 ();
  uart_bus_arbiter_if r1 ();

  uart_bus_arbiter #(
    .TO_W    (4),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_bus      (r0),
    .req1_bus      (r1),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_done  (uart_tx_done),
    .uart_rx_do    (uart_rx_do),
    .uart_rx_data  (uart_rx_data),
    .busy          (busy),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    r0.req = 1'b0; r0.done = 1'b0; r0.tx_start = 1'b1; r0.tx_data = 8'h00;
    r1.req = 1'b0; r1.done = 1'b0; r1.tx_start = 1'b1; r1.tx_data = 8'h00;
    uart_tx_done = 1'b0;
    uart_rx_do   = 1'b0;
    uart_rx_data = 8'h00;
    reset        = 1'b0;

    // Reset state
    #1;
    check("rst_grant0", r0.grant, 1'b0);
    check("rst_grant1", r1.grant, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_tx_start", uart_tx_start, 1'b1);
    check("rst_tx_data", uart_tx_data, 8'h00);
    uart_tx_done = 1'b1;
    uart_rx_do   = 1'b1;
    #1;
    check("rst_tx_done0", r0.tx_done, 1'b0);
    check("rst_rx_do1", r1.rx_do, 1'b0);
    uart_tx_done = 1'b0;
    uart_rx_do   = 1'b0;
    #1;
    reset = 1'b1;

    // Single requester 0: grant, zero-latency routing, gating
    r0.req = 1'b1;
    step();
    check("t1_grant0", r0.grant, 1'b1);
    check("t1_grant1", r1.grant, 1'b0);
    check("t1_busy", busy, 1'b1);
    r0.tx_start = 1'b0; r0.tx_data = 8'h01;
    r1.tx_start = 1'b0; r1.tx_data = 8'hff;
    #1;
    check("t1_uart_tx_start", uart_tx_start, 1'b0);
    check("t1_uart_tx_data", uart_tx_data, 8'h01);
    uart_tx_done = 1'b1;
    r1.done      = 1'b1;
    #1;
    check("t1_tx_done0", r0.tx_done, 1'b1);
    check("t1_tx_done1", r1.tx_done, 1'b0);
    step();
    uart_tx_done = 1'b0;
    r1.done      = 1'b0;
    r1.tx_start  = 1'b1; r1.tx_data = 8'h00;
    check("t1_nonowner_done", r0.grant, 1'b1);
    r0.done = 1'b1;
    step();
    r0.done = 1'b0;
    r0.req  = 1'b0;
    check("t1_gap_grant0", r0.grant, 1'b0);
    check("t1_gap_busy", busy, 1'b1);
    check("t1_gap_tx_start", uart_tx_start, 1'b1);
    uart_rx_do   = 1'b1;
    uart_rx_data = 8'h3c;
    #1;
    check("t1_gap_rx_do0", r0.rx_do, 1'b0);
    check("t1_gap_rx_do1", r1.rx_do, 1'b0);
    r0.tx_start = 1'b1; r0.tx_data = 8'h00;
    step();
    uart_rx_do = 1'b0;
    check("t1_idle_busy", busy, 1'b0);

    // Contention from reset: order 0,1,0,1
    reset = 1'b0;
    #1;
    reset = 1'b1;
    r0.req = 1'b1;
    r1.req = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("rr_grant0", r0.grant, (i % 2 == 0) ? 1'b1 : 1'b0);
      check("rr_grant1", r1.grant, (i % 2 == 1) ? 1'b1 : 1'b0);
      if (i == 1) begin
        uart_rx_do   = 1'b1;
        uart_rx_data = 8'ha5;
        #1;
        check("rx_do1", r1.rx_do, 1'b1);
        check("rx_data", r1.rx_data, 8'ha5);
        check("rx_do0", r0.rx_do, 1'b0);
        uart_rx_do = 1'b0;
      end
      if (i % 2 == 0) r0.done = 1'b1;
      else            r1.done = 1'b1;
      step();
      r0.done = 1'b0;
      r1.done = 1'b0;
      check("rr_gap_grants", {r0.grant, r1.grant}, 2'b00);
      check("rr_gap_busy", busy, 1'b1);
      step();
      check("rr_idle_busy", busy, 1'b0);
      step();
    end
    check("rr_wrap_grant0", r0.grant, 1'b1);
    r0.req = 1'b0;
    r1.req = 1'b0;
    step();
    check("drop_grant0", r0.grant, 1'b0);
    check("drop_timeout", timeout, 1'b0);
    step();

    // Watchdog expiry with no activity
    r0.req = 1'b1;
    step();
    check("wd_grant0", r0.grant, 1'b1);
    r1.req = 1'b1;
    for (int k = 1; k < 8; k++) begin
      step();
      check("wd_quiet", timeout, 1'b0);
    end
    step();
    check("wd_timeout", timeout, 1'b1);
    check("wd_grant0_drop", r0.grant, 1'b0);
    step();
    check("wd_timeout_pulse", timeout, 1'b0);
    check("wd_idle_busy", busy, 1'b0);
    step();
    check("wd_grant1", r1.grant, 1'b1);
    r0.req = 1'b0;
    r1.req = 1'b0;
    step();
    step();

    // Activity restarts the watchdog
    r0.req = 1'b1;
    step();
    check("wd2_grant0", r0.grant, 1'b1);
    for (int k = 1; k < 5; k++) step();
    uart_tx_done = 1'b1;
    #1;
    check("wd2_tx_done0", r0.tx_done, 1'b1);
    step();
    uart_tx_done = 1'b0;
    for (int k = 6; k < 13; k++) begin
      step();
      check("wd2_quiet", timeout, 1'b0);
    end
    step();
    check("wd2_timeout", timeout, 1'b1);
    r0.req = 1'b0;
    step();
    step();

    // done and expiry in the same cycle: done wins
    r0.req = 1'b1;
    step();
    for (int k = 1; k < 8; k++) begin
      step();
      check("co_quiet", timeout, 1'b0);
    end
    r0.done = 1'b1;
    step();
    r0.done = 1'b0;
    r0.req  = 1'b0;
    check("co_timeout", timeout, 1'b0);
    check("co_grant0", r0.grant, 1'b0);
    check("co_busy", busy, 1'b1);
    step();
    step();

    // Asynchronous reset mid-OWN
    r0.req = 1'b1;
    step();
    r0.tx_start = 1'b0;
    #1;
    check("ar_tx_start_own", uart_tx_start, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("ar_grant0", r0.grant, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_tx_start", uart_tx_start, 1'b1);
    check("ar_timeout", timeout, 1'b0);
    r0.req      = 1'b0;
    r0.tx_start = 1'b1;
    #1;
    reset = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
